// File: rtl/imu_gyro_unpacker.sv
// rtl/imu_gyro_unpacker.sv - MPU-6050 gyro burst unpacker with zero-rate bias calibration
// Stage 1 latches the raw burst; stage 2 either accumulates bias or emits corrected, saturated rates.
module imu_gyro_unpacker #(
   parameter int CALIB_SHIFT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               end_flag,
   input  logic               rd_phase,
   input  logic [7:0]         received_data [7:0],
   input  logic               recal,
   output logic signed [15:0] gyro_x,
   output logic signed [15:0] gyro_y,
   output logic signed [15:0] gyro_z,
   output logic               sample_valid,
   output logic               calib_done
);

   localparam int ACC_W = 16 + CALIB_SHIFT;
   localparam int CNT_W = CALIB_SHIFT + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << CALIB_SHIFT;

   typedef enum logic {S_CALIB, S_RUN} state_e;

   state_e                   state_q, state_d;
   logic                     flag_q;
   logic                     s1_valid_q, s1_valid_d;
   logic signed [15:0]       raw_q  [3];
   logic signed [15:0]       raw_d  [3];
   logic signed [15:0]       bias_q [3];
   logic signed [15:0]       bias_d [3];
   logic signed [15:0]       gyro_q [3];
   logic signed [15:0]       gyro_d [3];
   logic signed [ACC_W-1:0]  acc_q  [3];
   logic signed [ACC_W-1:0]  acc_d  [3];
   logic signed [ACC_W-1:0]  sum    [3];
   logic signed [16:0]       diff   [3];
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     valid_q, valid_d;
   logic                     done_q, done_d;
   logic                     accept;
   logic                     unused_bytes;

   function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
      if (v[16] != v[15]) begin
         return v[16] ? 16'sh8000 : 16'sh7FFF;
      end
      return v[15:0];
   endfunction

   // flag_q resets high so a completion already asserted at reset release is not taken
   assign accept       = end_flag & ~flag_q & rd_phase;
   assign unused_bytes = ^{received_data[6], received_data[7]};

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         sum[i]  = acc_q[i] + ACC_W'(raw_q[i]);
         diff[i] = 17'(raw_q[i]) - 17'(bias_q[i]);
      end
   end

   always_comb begin
      state_d    = state_q;
      s1_valid_d = accept & ~recal;
      raw_d      = raw_q;
      bias_d     = bias_q;
      gyro_d     = gyro_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      valid_d    = 1'b0;
      done_d     = done_q;

      if (accept) begin
         raw_d[0] = {received_data[0], received_data[1]};
         raw_d[1] = {received_data[2], received_data[3]};
         raw_d[2] = {received_data[4], received_data[5]};
      end

      if (recal) begin
         for (int i = 0; i < 3; i++) acc_d[i] = '0;
         cnt_d   = '0;
         done_d  = 1'b0;
         state_d = S_CALIB;
      end else if (s1_valid_q) begin
         case (state_q)
            S_CALIB: begin
               acc_d = sum;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_FULL) begin
                  for (int i = 0; i < 3; i++) bias_d[i] = 16'(sum[i] >>> CALIB_SHIFT);
                  done_d  = 1'b1;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < 3; i++) gyro_d[i] = sat16(diff[i]);
               valid_d = 1'b1;
            end
            default: state_d = S_CALIB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_CALIB;
         flag_q     <= 1'b1;
         s1_valid_q <= 1'b0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            raw_q[i]  <= '0;
            bias_q[i] <= '0;
            gyro_q[i] <= '0;
            acc_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         flag_q     <= end_flag;
         s1_valid_q <= s1_valid_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         raw_q      <= raw_d;
         bias_q     <= bias_d;
         gyro_q     <= gyro_d;
         acc_q      <= acc_d;
      end
   end

   assign gyro_x       = gyro_q[0];
   assign gyro_y       = gyro_q[1];
   assign gyro_z       = gyro_q[2];
   assign sample_valid = valid_q;
   assign calib_done   = done_q;

endmodule

// File: tb/tb_imu_gyro_unpacker.sv
// tb/tb_imu_gyro_unpacker.sv - directed table-driven bench for imu_gyro_unpacker (CALIB_SHIFT=2)
module tb_imu_gyro_unpacker;

   logic               clk;
   logic               rst_n;
   logic               end_flag;
   logic               rd_phase;
   logic [7:0]         rd_bytes [7:0];
   logic               recal;
   logic signed [15:0] gyro_x, gyro_y, gyro_z;
   logic               sample_valid;
   logic               calib_done;

   imu_gyro_unpacker #(.CALIB_SHIFT(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .end_flag     (end_flag),
      .rd_phase     (rd_phase),
      .received_data(rd_bytes),
      .recal        (recal),
      .gyro_x       (gyro_x),
      .gyro_y       (gyro_y),
      .gyro_z       (gyro_z),
      .sample_valid (sample_valid),
      .calib_done   (calib_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int vcount = 0;
   int v0;
   int done_n, done_n1, valid_n, valid_n1, valid_n2;
   int gx, gy, gz;

   always @(negedge clk) if (sample_valid === 1'b1) vcount++;

   typedef struct {
      logic [15:0] x, y, z;
      logic        rdp;
      int          hold;
      int          ex, ey, ez;
      int          ev;
   } vec_t;

   vec_t vt [5];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_bytes(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      rd_bytes[0] = x[15:8]; rd_bytes[1] = x[7:0];
      rd_bytes[2] = y[15:8]; rd_bytes[3] = y[7:0];
      rd_bytes[4] = z[15:8]; rd_bytes[5] = z[7:0];
      rd_bytes[6] = 8'hFF;   rd_bytes[7] = 8'hFF;
   endtask

   // Raise end_flag for 'hold' cycles; snapshot outputs after edges N, N+1, N+2.
   task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic rdp, input int hold, input logic rc);
      int n;
      n = (hold > 3) ? hold : 3;
      @(posedge clk); #1;
      set_bytes(x, y, z);
      rd_phase = rdp;
      end_flag = 1'b1;
      recal    = rc;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            recal   = 1'b0;
            done_n  = int'(calib_done);
            valid_n = int'(sample_valid);
         end
         if (c == 2) begin
            done_n1  = int'(calib_done);
            valid_n1 = int'(sample_valid);
            gx = int'(gyro_x); gy = int'(gyro_y); gz = int'(gyro_z);
         end
         if (c == 3) valid_n2 = int'(sample_valid);
         if (c == hold) end_flag = 1'b0;
      end
   endtask

   initial begin
      vt[0] = '{16'h0020, 16'h0000, 16'h0005, 1'b1, 2, 13, 2, 5, 1};
      vt[1] = '{16'h0013, 16'hFFFE, 16'h0000, 1'b1, 5, 0, 0, 0, 1};
      vt[2] = '{16'h1234, 16'h1234, 16'h1234, 1'b0, 2, 0, 0, 0, 0};
      vt[3] = '{16'h8000, 16'h7FFF, 16'hFFFF, 1'b1, 3, -32768, 32767, -1, 1};
      vt[4] = '{16'h7FFF, 16'h8000, 16'h0001, 1'b1, 1, 32748, -32766, 1, 1};

      rst_n = 1'b0; end_flag = 1'b1; rd_phase = 1'b1; recal = 1'b0;
      set_bytes(16'h0010, 16'hFFFE, 16'h0000);
      #2;
      check("reset_gyro_x", int'(gyro_x), 0);
      check("reset_gyro_y", int'(gyro_y), 0);
      check("reset_gyro_z", int'(gyro_z), 0);
      check("reset_valid", int'(sample_valid), 0);
      check("reset_done", int'(calib_done), 0);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 end_flag = 1'b0;

      v0 = vcount;
      pulse(16'h0010, 16'hFFFE, 16'h0000, 1'b1, 2, 1'b0);
      pulse(16'h7000, 16'h7000, 16'h7000, 1'b0, 2, 1'b0);
      pulse(16'h0012, 16'hFFFE, 16'h0000, 1'b1, 5, 1'b0);
      pulse(16'h0014, 16'hFFFE, 16'h0000, 1'b1, 1, 1'b0);
      check("calib_not_done_after_3", done_n1, 0);
      pulse(16'h0016, 16'hFFFE, 16'h0000, 1'b1, 2, 1'b0);
      check("calib_done_at_n", done_n, 0);
      check("calib_done_at_n1", done_n1, 1);
      check("calib_no_valid", vcount - v0, 0);

      for (int i = 0; i < 5; i++) begin
         v0 = vcount;
         pulse(vt[i].x, vt[i].y, vt[i].z, vt[i].rdp, vt[i].hold, 1'b0);
         check($sformatf("vec%0d_valid_n", i), valid_n, 0);
         check($sformatf("vec%0d_valid_n1", i), valid_n1, vt[i].ev);
         check($sformatf("vec%0d_valid_n2", i), valid_n2, 0);
         check($sformatf("vec%0d_gx", i), gx, vt[i].ex);
         check($sformatf("vec%0d_gy", i), gy, vt[i].ey);
         check($sformatf("vec%0d_gz", i), gz, vt[i].ez);
         check($sformatf("vec%0d_pulses", i), vcount - v0, vt[i].ev);
      end

      v0 = vcount;
      pulse(16'h0050, 16'h0050, 16'h0050, 1'b1, 2, 1'b1);
      check("recal_no_valid", valid_n1, 0);
      check("recal_done_low", done_n, 0);
      check("recal_hold_gx", gx, 32748);
      check("recal_hold_gy", gy, -32766);
      check("recal_hold_gz", gz, 1);
      for (int k = 0; k < 4; k++) pulse(16'hFFF0, 16'h0000, 16'h0000, 1'b1, 2, 1'b0);
      check("recal_fresh4_no_valid", vcount - v0, 0);
      check("recal_fresh4_done", done_n1, 1);
      pulse(16'h7FFF, 16'h0000, 16'h0000, 1'b1, 2, 1'b0);
      check("sat_pos_valid", valid_n1, 1);
      check("sat_pos_gx", gx, 32767);
      check("sat_pos_gy", gy, 0);

      @(posedge clk); #1 recal = 1'b1;
      @(posedge clk); #1 recal = 1'b0;
      check("recal_alone_done", int'(calib_done), 0);
      check("recal_alone_hold_gx", int'(gyro_x), 32767);
      for (int k = 0; k < 4; k++) pulse(16'h0010, 16'h0000, 16'h0000, 1'b1, 2, 1'b0);
      pulse(16'h8000, 16'h0000, 16'h0000, 1'b1, 2, 1'b0);
      check("sat_neg_gx", gx, -32768);

      v0 = vcount;
      @(posedge clk); #1;
      set_bytes(16'h0100, 16'h0100, 16'h0100);
      end_flag = 1'b1;
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check("async_rst_gx", int'(gyro_x), 0);
      check("async_rst_done", int'(calib_done), 0);
      @(posedge clk); #1;
      check("async_rst_no_valid", int'(sample_valid), 0);
      rst_n = 1'b1; end_flag = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("async_rst_pulses", vcount - v0, 0);
      check("async_rst_gx_after", int'(gyro_x), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
